// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - MemRead/MemWrite codes and responder FSM types shared with the control unit
package mem_pkg;

  localparam logic [2:0] MR_NONE = 3'd0;
  localparam logic [2:0] MR_LB   = 3'd1;
  localparam logic [2:0] MR_LH   = 3'd2;
  localparam logic [2:0] MR_LW   = 3'd3;
  localparam logic [2:0] MR_LBU  = 3'd4;
  localparam logic [2:0] MR_LHU  = 3'd5;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_SB   = 2'd1;
  localparam logic [1:0] MW_SH   = 2'd2;
  localparam logic [1:0] MW_SW   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] wdata;
  } req_t;

  // Codes 6 and 7 have no load meaning and are reported as faults.
  function automatic logic read_illegal(input logic [2:0] mr);
    return mr > MR_LHU;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane select, store merge and load extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] stored,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        misalign
);

  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_half;
  logic        is_word;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rd_data   = '0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    wr_word   = stored;

    case (addr_lo)
      2'd0:    byte_sel = stored[7:0];
      2'd1:    byte_sel = stored[15:8];
      2'd2:    byte_sel = stored[23:16];
      default: byte_sel = stored[31:24];
    endcase
    half_sel = addr_lo[1] ? stored[31:16] : stored[15:0];

    // Replicating the store data lets every lane pick its byte without a shifter.
    case (mem_write)
      MW_SB: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MW_SH: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        is_half   = 1'b1;
      end
      MW_SW: begin
        byte_en = 4'b1111;
        is_word = 1'b1;
      end
      default: ;
    endcase

    case (mem_read)
      MR_LB:  rd_data = {{24{byte_sel[7]}}, byte_sel};
      MR_LBU: rd_data = {24'd0, byte_sel};
      MR_LH: begin
        rd_data = {{16{half_sel[15]}}, half_sel};
        is_half = 1'b1;
      end
      MR_LHU: begin
        rd_data = {16'd0, half_sel};
        is_half = 1'b1;
      end
      MR_LW: begin
        rd_data = stored;
        is_word = 1'b1;
      end
      default: ;
    endcase

    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end

    misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - valid/ready data-memory slave with wait states and fault reporting
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e          state, state_nx;
  logic [CNT_W-1:0] cnt;
  req_t            req_q, cur;
  logic            accept, commit;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [29:0]     word_idx;
  logic [31:0]     stored, wr_word, rd_data;
  logic [3:0]      byte_en;
  logic            misalign, out_of_range, is_load, is_store, fault, do_write;

  always_comb begin
    state_nx  = state;
    commit    = 1'b0;
    accept    = 1'b0;
    cur       = req_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        accept    = req_valid && ((mem_read != MR_NONE) || (mem_write != MW_NONE));
        if (accept) begin
          // With no wait states the access commits on the accept edge straight from the inputs.
          if (LATENCY == 0) begin
            cur.addr      = addr;
            cur.mem_read  = mem_read;
            cur.mem_write = mem_write;
            cur.wdata     = wdata;
            commit        = 1'b1;
            state_nx      = RESP;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  assign word_idx     = cur.addr[31:2];
  assign out_of_range = word_idx >= 30'(DEPTH_WORDS);
  assign stored       = mem[word_idx[IDX_W-1:0]];
  assign is_load      = cur.mem_read != MR_NONE;
  assign is_store     = cur.mem_write != MW_NONE;
  assign fault        = misalign || out_of_range || read_illegal(cur.mem_read) || (is_load && is_store);
  assign do_write     = commit && !rst && !fault && is_store;

  mem_lane_align u_align (
    .mem_read  (cur.mem_read),
    .mem_write (cur.mem_write),
    .addr_lo   (cur.addr[1:0]),
    .stored    (stored),
    .wdata     (cur.wdata),
    .byte_en   (byte_en),
    .wr_word   (wr_word),
    .rd_data   (rd_data),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata   <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q.addr      <= addr;
        req_q.mem_read  <= mem_read;
        req_q.mem_write <= mem_write;
        req_q.wdata     <= wdata;
        cnt             <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rdata   <= (fault || !is_load) ? 32'd0 : rd_data;
        rsp_err <= fault;
      end
    end
  end

  // Storage is deliberately not reset; only committed, fault-free stores touch it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx[IDX_W-1:0]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed vector bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid0, rsp_ready, rsp_ready0;
  logic [31:0] addr, wdata;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rdata;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .wdata(wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rdata(rdata), .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .wdata(wdata), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rdata(rdata0), .rsp_err(rsp_err0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run(input bit sel, input logic [2:0] mr, input logic [1:0] mw,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    addr = a; mem_read = mr; mem_write = mw; wdata = wd;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    addr = 32'hFFFF_FFFC; mem_read = 3'd7; mem_write = MW_SW; wdata = 32'h5A5A_5A5A;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? rsp_valid0 : rsp_valid) && lat < 20);
    rd = sel ? rdata0 : rdata;
    er = sel ? rsp_err0 : rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " rdata"}, rdata, 32'd0);
    check({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  mr;
    logic [1:0]  mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b1; rsp_ready0 = 1'b1;
    addr = '0; wdata = '0; mem_read = MR_NONE; mem_write = MW_NONE;

    tbl.push_back('{MR_NONE, MW_SW, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h10, 32'h0,       32'hDEADBEEF, 1'b0});
    tbl.push_back('{MR_LB,   MW_NONE, 32'h13, 32'h0,       32'hFFFFFFDE, 1'b0});
    tbl.push_back('{MR_LBU,  MW_NONE, 32'h13, 32'h0,       32'h000000DE, 1'b0});
    tbl.push_back('{MR_LH,   MW_NONE, 32'h12, 32'h0,       32'hFFFFDEAD, 1'b0});
    tbl.push_back('{MR_LHU,  MW_NONE, 32'h10, 32'h0,       32'h0000BEEF, 1'b0});
    tbl.push_back('{MR_NONE, MW_SB, 32'h11,  32'h12345677, 32'h0,        1'b0});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h10, 32'h0,       32'hDEAD77EF, 1'b0});
    tbl.push_back('{MR_NONE, MW_SH, 32'h12,  32'h0000CAFE, 32'h0,        1'b0});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h10, 32'h0,       32'hCAFE77EF, 1'b0});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h12, 32'h0,       32'h0,        1'b1});
    tbl.push_back('{MR_NONE, MW_SW, 32'h400, 32'h99999999, 32'h0,        1'b1});
    tbl.push_back('{MR_NONE, MW_SH, 32'h11,  32'h00001111, 32'h0,        1'b1});
    tbl.push_back('{3'd6,    MW_NONE, 32'h10, 32'h0,       32'h0,        1'b1});
    tbl.push_back('{MR_LB,   MW_SB, 32'h10,  32'h000000FF, 32'h0,        1'b1});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h10, 32'h0,       32'hCAFE77EF, 1'b0});
    tbl.push_back('{MR_LB,   MW_NONE, 32'h11, 32'h0,       32'h00000077, 1'b0});
    tbl.push_back('{MR_LH,   MW_NONE, 32'h10, 32'h0,       32'h000077EF, 1'b0});
    tbl.push_back('{MR_NONE, MW_SW, 32'h3FC, 32'h80000001, 32'h0,        1'b0});
    tbl.push_back('{MR_LW,   MW_NONE, 32'h3FC, 32'h0,      32'h80000001, 1'b0});
    tbl.push_back('{MR_LB,   MW_NONE, 32'h3FF, 32'h0,      32'hFFFFFF80, 1'b0});

    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // A request with no access type must be ignored.
    @(negedge clk) req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("ignored busy", {31'd0, busy}, 32'd0);
    check("ignored req_ready", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i]) begin
      run(1'b0, tbl[i].mr, tbl[i].mw, tbl[i].a, tbl[i].wd, rd, er, lat);
      check($sformatf("v%0d rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("v%0d rsp_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      check($sformatf("v%0d latency", i), lat, 32'd3);
    end

    // Backpressure: response held while rsp_ready is low.
    rsp_ready = 1'b0;
    @(negedge clk);
    addr = 32'h10; mem_read = MR_LW; mem_write = MW_NONE; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp valid arrives", n, 32'd3);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("bp c%0d hold", c), {28'd0, rsp_valid, req_ready, busy, rsp_err}, 32'b1010);
      check($sformatf("bp c%0d rdata", c), rdata, 32'hCAFE77EF);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(negedge clk);
    check("bp done", {30'd0, rsp_valid, busy}, 32'd0);

    // Reset during WAIT drops the store.
    run(1'b0, MR_NONE, MW_SW, 32'h20, 32'h0, rd, er, lat);
    @(negedge clk);
    addr = 32'h20; mem_read = MR_NONE; mem_write = MW_SW; wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 check_reset_outputs("async rst wait");
    @(negedge clk) rst = 1'b0;
    run(1'b0, MR_LW, MW_NONE, 32'h20, 32'h0, rd, er, lat);
    check("dropped store rdata", rd, 32'h0);
    check("dropped store err", {31'd0, er}, 32'd0);

    // Reset while a response is pending discards it.
    rsp_ready = 1'b0;
    @(negedge clk);
    addr = 32'h10; mem_read = MR_LW; mem_write = MW_NONE; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("resp pending", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1 check_reset_outputs("async rst resp");
    @(negedge clk) begin rst = 1'b0; rsp_ready = 1'b1; end

    // Zero wait states.
    run(1'b1, MR_NONE, MW_SW, 32'h44, 32'hA5A51234, rd, er, lat);
    check("l0 sw latency", lat, 32'd1);
    check("l0 sw err", {31'd0, er}, 32'd0);
    run(1'b1, MR_LW, MW_NONE, 32'h44, 32'h0, rd, er, lat);
    check("l0 lw rdata", rd, 32'hA5A51234);
    check("l0 lw latency", lat, 32'd1);
    run(1'b1, MR_LH, MW_NONE, 32'h46, 32'h0, rd, er, lat);
    check("l0 lh rdata", rd, 32'hFFFFA5A5);
    run(1'b1, MR_LW, MW_NONE, 32'h46, 32'h0, rd, er, lat);
    check("l0 misalign err", {31'd0, er}, 32'd1);
    check("l0 misalign rdata", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory slave answering the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Implements byte, halfword and word accesses using the control unit's MemRead/MemWrite encodings, with sign/zero extension and alignment checking.
- A programmable wait-state count lets the datapath be exercised against non-zero memory latency.
- Sits between the datapath (address from ALU result, store data from register outData2) and the register write-back mux.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; word index = addr[31:2].
- LATENCY, 2: wait cycles between request accept and access commit; 0 is legal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- addr  input  32  byte address
- mem_read  input  3  load type: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu; 6 and 7 illegal
- mem_write  input  2  store type: 0 none, 1 sb, 2 sh, 3 sw
- wdata  input  32  store data; the low byte or low halfword is used for sb/sh
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  request was faulted; no memory side effect occurred
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, busy=0, wait counter=0.
  - Memory array is not reset; its contents are undefined until written.
- States:
  - IDLE: req_ready=1. If req_valid is high and (mem_read!=0 or mem_write!=0), latch addr/mem_read/mem_write/wdata. Go to WAIT if LATENCY>0, otherwise go straight to the commit step.
  - A request with both fields 0 is ignored; req_ready stays 1.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle. When the counter reaches 0, commit and go to RESP.
  - Commit: perform the store or capture the load, register rdata and rsp_err, assert rsp_valid.
  - RESP: rsp_valid=1, outputs held stable. When rsp_ready is high, return to IDLE.
  - A new request is never accepted in the same cycle a response completes; it waits for IDLE.
- Latency:
  - Accept edge to rsp_valid high = LATENCY+1 cycles.
  - With rsp_ready tied high, one transaction completes every LATENCY+2 cycles.
- Faults (rsp_err=1, rdata=0, no write). All are checked at commit using the latched fields:
  - halfword access with addr[0]=1
  - word access with addr[1:0]!=0
  - word index >= DEPTH_WORDS
  - mem_read in {6,7}
  - mem_read!=0 and mem_write!=0 simultaneously
- Little-endian byte lanes:
  - sb writes byte addr[1:0] only.
  - sh writes half addr[1] only.
  - sw writes all four bytes.
  - Unselected bytes are preserved.
- Load extension:
  - lb/lh sign-extend bit 7/15 of the selected lane.
  - lbu/lhu zero-extend.
  - lw returns the full word.
- Reset mid-transaction: any uncommitted store is dropped, and an in-flight response is discarded.
- Inputs may change after accept without effect, because fields are latched.
- Back-to-back access to the same address: a store followed by a load returns the stored data, since the store committed before RESP.

Decomposition:
- Shared package mem_pkg:
  - MemRead codes: MR_NONE, MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU.
  - MemWrite codes: MW_NONE, MW_SB, MW_SH, MW_SW.
  - FSM state encoding: IDLE, WAIT, RESP.
  - These same constants are to be used by the control unit.
- One combinational sub-module, mem_lane_align:
  - Inputs: latched type, addr[1:0], stored word, wdata.
  - Outputs: 4-bit byte enable, merged write word, extended load data, misalign flag.
- The top level holds the FSM, counter and array.

Test Plan:
- Setup: LATENCY=2. sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10. Expect rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, rsp_err=0.
- Byte/half loads on that word:
  - lb 0x13 -> 0xFFFFFFDE
  - lbu 0x13 -> 0x000000DE
  - lh 0x12 -> 0xFFFFDEAD
  - lhu 0x10 -> 0x0000BEEF
- Partial stores:
  - sb 0x11 wdata=0x12345677 -> lw 0x10 = 0xDEAD77EF
  - sh 0x12 wdata=0x0000CAFE -> lw 0x10 = 0xCAFE77EF
- Faults:
  - lw 0x12 -> rsp_err=1, rdata=0
  - sw 0x400 (index 256) -> rsp_err=1
  - sh 0x11 -> rsp_err=1
  - A subsequent lw 0x10 returns 0xCAFE77EF, unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles on an lw. rsp_valid and rdata stay stable, req_ready=0 and busy=1 throughout; completion occurs on the first cycle rsp_ready=1.
- Reset mid-op: start sw 0x20 wdata=0x11111111 after a prior sw 0x20 of 0x0. Pulse rst during WAIT: all outputs return to reset values immediately. Then lw 0x20 returns 0x00000000. Repeat with LATENCY=0: rsp_valid arrives 1 cycle after accept.
